// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard transmitter.
// PS2_TX_PARITY_INJECT_EN adds a parity-corruption flag to each queued entry.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned CODE_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BIT_HI,
    BIT_LO,
    GAP
  } ps2_tx_state_t;

`ifdef PS2_TX_PARITY_INJECT_EN
  typedef struct packed {
    logic              inject;
    logic [CODE_W-1:0] code;
  } ps2_entry_t;
`else
  typedef struct packed {
    logic [CODE_W-1:0] code;
  } ps2_entry_t;
`endif

  function automatic logic odd_parity(input logic [CODE_W-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous scan-code FIFO; count and ready are registered, head is a
// combinational read of the entry at the read pointer.
module ps2_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_head_c,
  output logic                    o_ready,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_ready;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign w_push_ok = i_push && r_ready;
  assign w_pop_ok  = i_pop && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_ready  = r_ready;
  assign o_count  = r_count;

endmodule

// File: rtl/ps2_keyboard_transmitter.sv
// Device-side PS/2 keyboard: queues scan codes and serialises them as 11-bit
// frames on ps2_clk/ps2_data. Define PS2_TX_PARITY_INJECT_EN for inject_err.
module ps2_keyboard_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
`ifdef PS2_TX_PARITY_INJECT_EN
  input  logic                         inject_err,
`endif
  output logic                         in_ready,
  output logic                         ps2_clk,
  output logic                         ps2_data,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned PH_W    = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = $clog2(FRAME_BITS);
  localparam int unsigned ENT_W   = $bits(ps2_entry_t);

  ps2_tx_state_t         r_state;
  ps2_tx_state_t         w_state_next;
  logic [PH_W-1:0]       r_phase;
  logic [PH_W-1:0]       w_phase_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_next;
  logic                  r_ps2_clk;
  logic                  w_clk_next;
  logic                  r_ps2_data;
  logic                  w_data_next;
  logic                  r_busy;
  logic                  w_pop;
  logic                  w_parity;
  ps2_entry_t            w_push_entry;
  ps2_entry_t            w_head;
  logic [ENT_W-1:0]      w_head_bits;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.code = in_data;
`ifdef PS2_TX_PARITY_INJECT_EN
    w_push_entry.inject = inject_err;
`endif
  end

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (in_valid),
    .i_data   (w_push_entry),
    .i_pop    (w_pop),
    .o_head_c (w_head_bits),
    .o_ready  (in_ready),
    .o_count  (fifo_count)
  );

  assign w_head = ps2_entry_t'(w_head_bits);

`ifdef PS2_TX_PARITY_INJECT_EN
  assign w_parity = odd_parity(w_head.code) ^ w_head.inject;
`else
  assign w_parity = odd_parity(w_head.code);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_idx      <= w_idx_next;
      r_shift    <= w_shift_next;
      r_ps2_clk  <= w_clk_next;
      r_ps2_data <= w_data_next;
      r_busy     <= (w_state_next != IDLE);
    end
  end

  // Frame sequencer: data only moves on the cycle ps2_clk rises.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_clk_next   = r_ps2_clk;
    w_data_next  = r_ps2_data;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_next  = 1'b1;
        w_data_next = 1'b1;
        if (fifo_count != '0) begin
          w_pop        = 1'b1;
          w_shift_next = {1'b1, w_parity, w_head.code, 1'b0};
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_data_next  = r_shift[0];
        w_shift_next = {1'b1, r_shift[FRAME_BITS-1:1]};
        w_idx_next   = '0;
        w_phase_next = '0;
        w_state_next = BIT_HI;
      end
      BIT_HI: begin
        if (r_phase == PH_W'(HALF_PERIOD - 1)) begin
          w_phase_next = '0;
          w_clk_next   = 1'b0;
          w_state_next = BIT_LO;
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      BIT_LO: begin
        if (r_phase == PH_W'(HALF_PERIOD - 1)) begin
          w_phase_next = '0;
          w_clk_next   = 1'b1;
          if (r_idx == IDX_W'(FRAME_BITS - 1)) begin
            w_data_next  = 1'b1;
            w_state_next = GAP;
          end else begin
            w_idx_next   = r_idx + IDX_W'(1);
            w_data_next  = r_shift[0];
            w_shift_next = {1'b1, r_shift[FRAME_BITS-1:1]};
            w_state_next = BIT_HI;
          end
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      GAP: begin
        w_clk_next  = 1'b1;
        w_data_next = 1'b1;
        if (r_phase == PH_W'(GAP_CYCLES - 1)) begin
          w_phase_next = '0;
          w_state_next = IDLE;
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign ps2_clk  = r_ps2_clk;
  assign ps2_data = r_ps2_data;
  assign busy     = r_busy;

endmodule

// File: tb/tb_ps2_keyboard_transmitter.sv
// Bench for ps2_keyboard_transmitter: a PS/2 receiver model decodes frames and
// checks them against a queue of bytes recorded at push time.
module tb_ps2_keyboard_transmitter;

  localparam int unsigned HP    = 4;
  localparam int unsigned GAPC  = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ps2_clk;
  logic          ps2_data;
  logic          busy;
  logic [CW-1:0] fifo_count;
`ifdef PS2_TX_PARITY_INJECT_EN
  logic          inject_err;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       bad;
  } exp_t;

  exp_t  exp_q[$];
  int    start_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cycle    = 0;

  ps2_keyboard_transmitter #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAPC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
`ifdef PS2_TX_PARITY_INJECT_EN
    .inject_err (inject_err),
`endif
    .in_ready   (in_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Receiver model: samples data on each falling ps2_clk.
  logic        prev_clk  = 1'b1;
  logic        prev_data = 1'b1;
  int          nbits     = 0;
  int          last_fall = 0;
  logic [10:0] fr        = '0;
  logic [10:0] last_fr   = '0;
  logic        frame_ok;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      nbits     = 0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (nbits == 0 && prev_data && !ps2_data && ps2_clk) start_q.push_back(cycle);
      if (prev_clk && !ps2_clk) begin
        if (nbits > 0) begin
          checks++;
          if (cycle - last_fall != 2 * HP) begin
            failures++;
            $display("FAIL fall_spacing got=%0d exp=%0d", cycle - last_fall, 2 * HP);
          end
        end
        last_fall = cycle;
        fr        = {ps2_data, fr[10:1]};
        nbits++;
        if (nbits == 11) begin
          nbits    = 0;
          last_fr  = fr;
          frame_ok = !fr[0] && fr[10] && (^fr[9:1]);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rx_unexpected frame=%03h exp=none", fr);
          end else begin
            e = exp_q.pop_front();
            if (e.bad && frame_ok) begin
              failures++;
              $display("FAIL rx_inject_kept frame=%03h exp=bad_parity", fr);
            end else if (!e.bad && (!frame_ok || fr[8:1] !== e.data)) begin
              failures++;
              $display("FAIL rx_byte got=%02h ok=%0b exp=%02h ok=1", fr[8:1], frame_ok, e.data);
            end
          end
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // Returns #1 after the edge that accepted the byte.
  task automatic push(input logic [7:0] d, input logic bad);
    int t = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
`ifdef PS2_TX_PARITY_INJECT_EN
    inject_err = bad;
`endif
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      failures++;
      $display("FAIL push_timeout byte=%02h in_ready=%0b exp=1", d, in_ready);
    end
    @(posedge clk);
    exp_q.push_back('{data: d, bad: bad});
    #1;
    in_valid = 1'b0;
`ifdef PS2_TX_PARITY_INJECT_EN
    inject_err = 1'b0;
`endif
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || busy || fifo_count != '0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 5000) begin
      failures++;
      $display("FAIL %s_idle_timeout pending=%0d exp=0", tag, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (ps2_clk !== 1'b1)    begin failures++; $display("FAIL reset_ps2_clk got=%b exp=1", ps2_clk); end
    if (ps2_data !== 1'b1)   begin failures++; $display("FAIL reset_ps2_data got=%b exp=1", ps2_data); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (fifo_count !== '0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    int n;
    start_q.delete();
    push(8'h1C, 1'b0);
    n = cycle;
    wait_idle("single");
    checks += 3;
    if (start_q.size() < 1 || start_q[0] - n != 2) begin
      failures++;
      $display("FAIL latency got=%0d exp=2", (start_q.size() > 0) ? start_q[0] - n : -1);
    end
    if (last_fr[9] !== 1'b0) begin failures++; $display("FAIL parity_1c got=%b exp=0", last_fr[9]); end
    if (last_fr[8:1] !== 8'h1C) begin failures++; $display("FAIL byte_1c got=%02h exp=1c", last_fr[8:1]); end
  endtask

  task automatic test_back_to_back();
    start_q.delete();
    push(8'hF0, 1'b0);
    push(8'h1C, 1'b0);
    // Second push lands on the pop edge of the first byte.
    checks++;
    if (fifo_count !== CW'(1)) begin failures++; $display("FAIL pushpop_count got=%0d exp=1", fifo_count); end
    wait_idle("b2b");
    // Start-to-start: frame, gap, then the IDLE pop and LOAD cycles.
    checks++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != int'(22 * HP + GAPC + 2)) begin
      failures++;
      $display("FAIL frame_spacing got=%0d exp=%0d",
               (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, 22 * HP + GAPC + 2);
    end
  endtask

  task automatic test_fill();
    int a;
    logic [7:0] b;
    for (int i = 0; i < 9; i++) begin
      b = 8'(i * 27 + 5);
      push(b, 1'b0);
      if (i == 0) a = cycle;
    end
    checks += 2;
    if (in_ready !== 1'b0)     begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    if (fifo_count !== CW'(8)) begin failures++; $display("FAIL full_count got=%0d exp=8", fifo_count); end
    push(8'hAB, 1'b0);
    checks += 3;
    if (cycle - a != int'(2 + 22 * HP + GAPC + 2)) begin
      failures++;
      $display("FAIL held_push_cycle got=%0d exp=%0d", cycle - a, 2 + 22 * HP + GAPC + 2);
    end
    if (fifo_count !== CW'(8)) begin failures++; $display("FAIL refill_count got=%0d exp=8", fifo_count); end
    if (in_ready !== 1'b0)     begin failures++; $display("FAIL refill_ready got=%b exp=0", in_ready); end
    wait_idle("fill");
  endtask

  task automatic test_reset_mid();
    int t = 0;
    push(8'h5A, 1'b0);
    push(8'h77, 1'b0);
    while (nbits != 5 && t < 500) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 500) begin failures++; $display("FAIL midreset_wait nbits=%0d exp=5", nbits); end
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (ps2_clk !== 1'b1)  begin failures++; $display("FAIL midreset_clk got=%b exp=1", ps2_clk); end
    if (ps2_data !== 1'b1) begin failures++; $display("FAIL midreset_data got=%b exp=1", ps2_data); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    if (fifo_count !== '0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", fifo_count); end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    push(8'h33, 1'b0);
    wait_idle("after_reset");
  endtask

`ifdef PS2_TX_PARITY_INJECT_EN
  task automatic test_inject();
    push(8'h00, 1'b1);
    push(8'h00, 1'b0);
    wait_idle("inject");
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
`ifdef PS2_TX_PARITY_INJECT_EN
    inject_err = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid();
`ifdef PS2_TX_PARITY_INJECT_EN
    test_inject();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d exp=finished", cycle);
    $fatal(1);
  end

endmodule
